// File: rtl/aesha_job_sched.sv
// -----------------------------------------------------------------------------
// aesha_job_sched
// Job front-end for the AESHA AES/Keccak core. It queues tagged requests in a
// small FIFO, issues them one at a time to the core, and returns each result
// with its tag through a valid/ready result port. Key expansion is requested
// only when an AES job's key differs from the key the core last expanded.
//
// Ports
//   i_clk, i_reset_n                 clock, asynchronous active-low reset
//   i_req_* / o_req_ready            request port (mode, direction, key, data, tag)
//   o_res_* / i_res_ready            result port (data, tag, watchdog error)
//   o_core_*                         core control and operands
//   i_core_data, i_core_done         core result and done pulse
//   o_busy, o_level                  activity flag and FIFO occupancy
//
// Build option
//   AESHA_SCHED_TMO_EN  enables the RUN watchdog (TMO_CYC cycles). A job that
//                       times out returns o_res_err=1 with all-zero data and
//                       invalidates the key cache. Without the macro RUN waits
//                       for i_core_done indefinitely and o_res_err is 0.
// -----------------------------------------------------------------------------
module aesha_job_sched #(
    parameter int DATA_W  = 512,
    parameter int KEY_W   = 128,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_aes_or_keccak,
    input  logic                       i_req_enc_or_dec,
    input  logic [KEY_W-1:0]           i_req_key,
    input  logic [DATA_W-1:0]          i_req_data,
    input  logic [TAG_W-1:0]           i_req_tag,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [DATA_W-1:0]          o_res_data,
    output logic [TAG_W-1:0]           o_res_tag,
    output logic                       o_res_err,
    output logic                       o_core_aclr,
    output logic                       o_core_aes_or_keccak,
    output logic                       o_core_enc_or_dec,
    output logic                       o_core_genkey,
    output logic [KEY_W-1:0]           o_core_key,
    output logic [DATA_W-1:0]          o_core_data,
    input  logic [DATA_W-1:0]          i_core_data,
    input  logic                       i_core_done,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Pointer wrap relies on DEPTH being a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TMO_CYC < 1)) begin : g_param_check
        $error("aesha_job_sched: DEPTH must be a power of two >= 2 and TMO_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;

    // FIFO storage and bookkeeping
    logic                mode_mem_r [DEPTH];
    logic                dir_mem_r  [DEPTH];
    logic [KEY_W-1:0]    key_mem_r  [DEPTH];
    logic [DATA_W-1:0]   data_mem_r [DEPTH];
    logic [TAG_W-1:0]    tag_mem_r  [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [LW-1:0]       level_r;
    logic [LW-1:0]       level_s;
    logic                ready_r;
    logic                push_s;
    logic                pop_s;

    // Job register (drives the core operands)
    logic                job_mode_r;
    logic                job_dir_r;
    logic [KEY_W-1:0]    job_key_r;
    logic [DATA_W-1:0]   job_data_r;
    logic [TAG_W-1:0]    job_tag_r;

    // Key cache
    logic                cache_valid_r;
    logic [KEY_W-1:0]    cache_key_r;
    logic                genkey_calc_s;

    // Result and registered control outputs
    logic [DATA_W-1:0]   res_data_r;
    logic [TAG_W-1:0]    res_tag_r;
    logic                res_valid_r;
    logic                aclr_r;
    logic                genkey_r;
    logic                busy_r;
    logic                done_s;
    logic                tmo_hit_s;

    assign push_s = i_req_valid && ready_r;
    assign pop_s  = (state_r == ST_IDLE) && (level_r != LVL_ZERO);
    assign done_s = (state_r == ST_RUN) && i_core_done;

    // A key counts as already expanded only for AES with a valid matching cache.
    assign genkey_calc_s = !job_mode_r && !(cache_valid_r && (job_key_r == cache_key_r));

    // Next FIFO occupancy from this cycle's push/pop
    always_comb begin
        level_s = level_r;
        if (push_s && !pop_s) begin
            level_s = level_r + LVL_ONE;
        end else if (!push_s && pop_s) begin
            level_s = level_r - LVL_ONE;
        end else begin
            level_s = level_r;
        end
    end

    // FIFO storage write; contents are don't-care while an entry is unoccupied
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mode_mem_r[wr_ptr_r] <= i_req_aes_or_keccak;
            dir_mem_r[wr_ptr_r]  <= i_req_enc_or_dec;
            key_mem_r[wr_ptr_r]  <= i_req_key;
            data_mem_r[wr_ptr_r] <= i_req_data;
            tag_mem_r[wr_ptr_r]  <= i_req_tag;
        end
    end

    // FIFO pointers, level and the registered not-full flag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_s;
            // Ready looks at the next level only, so a full FIFO never takes a push.
            ready_r <= (level_s != LVL_FULL);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; done has priority over the watchdog
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (level_r != LVL_ZERO) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (i_core_done || tmo_hit_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RESP: begin
                if (i_res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Job register: loaded from the FIFO head on pop, held until the next pop
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            job_mode_r <= 1'b0;
            job_dir_r  <= 1'b0;
            job_key_r  <= {KEY_W{1'b0}};
            job_data_r <= {DATA_W{1'b0}};
            job_tag_r  <= {TAG_W{1'b0}};
        end else if (pop_s) begin
            job_mode_r <= mode_mem_r[rd_ptr_r];
            job_dir_r  <= dir_mem_r[rd_ptr_r];
            job_key_r  <= key_mem_r[rd_ptr_r];
            job_data_r <= data_mem_r[rd_ptr_r];
            job_tag_r  <= tag_mem_r[rd_ptr_r];
        end
    end

    // Key cache: remembers the last AES key the core finished with
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cache_valid_r <= 1'b0;
            cache_key_r   <= {KEY_W{1'b0}};
        end else if (done_s && !job_mode_r) begin
            cache_valid_r <= 1'b1;
            cache_key_r   <= job_key_r;
        end else if (tmo_hit_s) begin
            // An aborted job leaves the core's key schedule in an unknown state.
            cache_valid_r <= 1'b0;
        end
    end

    // Result register: captured once per job, stable for all of RESP
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            res_data_r <= {DATA_W{1'b0}};
            res_tag_r  <= {TAG_W{1'b0}};
        end else if (done_s) begin
            res_data_r <= i_core_data;
            res_tag_r  <= job_tag_r;
        end else if (tmo_hit_s) begin
            res_data_r <= {DATA_W{1'b0}};
            res_tag_r  <= job_tag_r;
        end
    end

    // Registered control outputs derived from the next state
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            aclr_r      <= 1'b1;
            genkey_r    <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            aclr_r      <= (state_s != ST_RUN);
            res_valid_r <= (state_s == ST_RESP);
            busy_r      <= (state_s != ST_IDLE) || (level_s != LVL_ZERO);
            // genkey is decided in LOAD and held for the whole RUN phase.
            if (state_r == ST_LOAD) begin
                genkey_r <= genkey_calc_s;
            end else if (state_s != ST_RUN) begin
                genkey_r <= 1'b0;
            end
        end
    end

`ifdef AESHA_SCHED_TMO_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] tmo_cnt_r;
    logic          res_err_r;

    // Counter holds the number of RUN cycles already completed; the
    // TMO_CYC-th RUN cycle without done is the abort point.
    assign tmo_hit_s = (state_r == ST_RUN) && !i_core_done && (tmo_cnt_r == CNT_LAST);
    assign o_res_err = res_err_r;

    // Watchdog cycle counter, cleared outside RUN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt_r <= CNT_ZERO;
        end else if (state_r == ST_RUN) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
        end else begin
            tmo_cnt_r <= CNT_ZERO;
        end
    end

    // Error flag of the current result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            res_err_r <= 1'b0;
        end else if (done_s) begin
            res_err_r <= 1'b0;
        end else if (tmo_hit_s) begin
            res_err_r <= 1'b1;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign o_res_err = 1'b0;
`endif

    assign o_req_ready          = ready_r;
    assign o_level              = level_r;
    assign o_busy               = busy_r;
    assign o_res_valid          = res_valid_r;
    assign o_res_data           = res_data_r;
    assign o_res_tag            = res_tag_r;
    assign o_core_aclr          = aclr_r;
    assign o_core_genkey        = genkey_r;
    assign o_core_aes_or_keccak = job_mode_r;
    assign o_core_enc_or_dec    = job_dir_r;
    assign o_core_key           = job_key_r;
    assign o_core_data          = job_data_r;

endmodule

// File: tb/tb_aesha_job_sched.sv
// -----------------------------------------------------------------------------
// tb_aesha_job_sched
// Scoreboard bench: each push queues the expected core operands (including the
// hand-derived genkey bit) and the expected result. A core stub answers with
// the inverted input block. Two monitors pop and compare independently.
// -----------------------------------------------------------------------------
module tb_aesha_job_sched;

    localparam int DATA_W  = 512;
    localparam int KEY_W   = 128;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TMO_CYC = 16;
    localparam int LW      = 3;

    localparam logic [KEY_W-1:0] K1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [KEY_W-1:0] K2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [KEY_W-1:0] K3 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [KEY_W-1:0] K4 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [KEY_W-1:0] K5 = 128'h55555555_aaaaaaaa_55555555_aaaaaaaa;
    localparam logic [KEY_W-1:0] K6 = 128'h0f0f0f0f_f0f0f0f0_12121212_34343434;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_mode;
    logic              req_dir;
    logic [KEY_W-1:0]  req_key;
    logic [DATA_W-1:0] req_data;
    logic [TAG_W-1:0]  req_tag;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;
    logic              core_aclr;
    logic              core_mode;
    logic              core_dir;
    logic              core_genkey;
    logic [KEY_W-1:0]  core_key;
    logic [DATA_W-1:0] core_din;
    logic [DATA_W-1:0] core_dout;
    logic              core_done;
    logic              busy;
    logic [LW-1:0]     level;

    int n_tests = 0;
    int n_fail  = 0;
    logic stall = 1'b0;

    typedef struct {
        logic              genkey;
        logic              mode;
        logic              dir;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
    } core_exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } res_exp_t;

    core_exp_t exp_core[$];
    res_exp_t  exp_res[$];

    always #5 clk = ~clk;

    aesha_job_sched #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_aes_or_keccak(req_mode),
        .i_req_enc_or_dec(req_dir),
        .i_req_key(req_key),
        .i_req_data(req_data),
        .i_req_tag(req_tag),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_data(res_data),
        .o_res_tag(res_tag),
        .o_res_err(res_err),
        .o_core_aclr(core_aclr),
        .o_core_aes_or_keccak(core_mode),
        .o_core_enc_or_dec(core_dir),
        .o_core_genkey(core_genkey),
        .o_core_key(core_key),
        .o_core_data(core_din),
        .i_core_data(core_dout),
        .i_core_done(core_done),
        .o_busy(busy),
        .o_level(level)
    );

    task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [DATA_W-1:0] mkdata(input int i);
        logic [31:0] w;
        w = 32'hA5C30000 ^ i[31:0];
        return {16{w}};
    endfunction

    // Core stub: done on the third RUN cycle unless stalled, result = ~input.
    initial begin
        int run_cnt;
        run_cnt   = 0;
        core_done = 1'b0;
        core_dout = {DATA_W{1'b0}};
        forever begin
            @(posedge clk);
            #1;
            if (core_aclr === 1'b0) run_cnt++;
            else run_cnt = 0;
            if (core_aclr === 1'b0 && !stall && run_cnt >= 3) begin
                core_done = 1'b1;
                core_dout = ~core_din;
            end else begin
                core_done = 1'b0;
            end
        end
    end

    // Core-side monitor: operands at RUN entry, genkey in every RUN cycle.
    initial begin
        bit        in_run;
        bit        have;
        core_exp_t cur;
        in_run = 1'b0;
        have   = 1'b0;
        forever begin
            @(negedge clk);
            if (core_aclr === 1'b0) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    if (exp_core.size() == 0) begin
                        have = 1'b0;
                        fail_now("core_unexpected_job");
                    end else begin
                        have = 1'b1;
                        cur  = exp_core.pop_front();
                        check("core_mode", DATA_W'(core_mode), DATA_W'(cur.mode));
                        check("core_dir",  DATA_W'(core_dir),  DATA_W'(cur.dir));
                        check("core_key",  DATA_W'(core_key),  DATA_W'(cur.key));
                        check("core_data", core_din, cur.data);
                    end
                end
                if (have) check("core_genkey", DATA_W'(core_genkey), DATA_W'(cur.genkey));
            end else begin
                in_run = 1'b0;
            end
        end
    end

    // Result-side monitor: compare each accepted result in order.
    initial begin
        res_exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_res.size() == 0) begin
                    fail_now("res_unexpected");
                end else begin
                    e = exp_res.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_tag",  DATA_W'(res_tag), DATA_W'(e.tag));
                    check("res_err",  DATA_W'(res_err), DATA_W'(e.err));
                end
            end
        end
    end

    task automatic push(input logic mode, input logic [KEY_W-1:0] key, input int di,
                        input logic [TAG_W-1:0] tag, input logic gk, input logic err);
        core_exp_t ce;
        res_exp_t  re;
        int        guard;
        req_valid = 1'b1;
        req_mode  = mode;
        req_dir   = tag[0];
        req_key   = key;
        req_data  = mkdata(di);
        req_tag   = tag;
        guard     = 0;
        while (req_ready !== 1'b1 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (req_ready !== 1'b1) begin
            fail_now("push_timeout");
        end else begin
            ce.genkey = gk;
            ce.mode   = mode;
            ce.dir    = tag[0];
            ce.key    = key;
            ce.data   = mkdata(di);
            exp_core.push_back(ce);
            re.data   = err ? {DATA_W{1'b0}} : ~mkdata(di);
            re.tag    = tag;
            re.err    = err;
            exp_res.push_back(re);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while ((exp_res.size() != 0 || exp_core.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_res.size() != 0 || exp_core.size() != 0) begin
            fail_now({nm, "_drain_timeout"});
            exp_res.delete();
            exp_core.delete();
        end
        repeat (2) @(negedge clk);
        check({nm, "_idle_busy"},  DATA_W'(busy),  DATA_W'(1'b0));
        check({nm, "_idle_level"}, DATA_W'(level), DATA_W'(3'd0));
    endtask

    initial begin
        int g;
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int g;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_dir   = 1'b0;
        req_key   = {KEY_W{1'b0}};
        req_data  = {DATA_W{1'b0}};
        req_tag   = {TAG_W{1'b0}};
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  DATA_W'(req_ready),   DATA_W'(1'b1));
        check("rst_level",  DATA_W'(level),       DATA_W'(3'd0));
        check("rst_aclr",   DATA_W'(core_aclr),   DATA_W'(1'b1));
        check("rst_valid",  DATA_W'(res_valid),   DATA_W'(1'b0));
        check("rst_genkey", DATA_W'(core_genkey), DATA_W'(1'b0));
        check("rst_busy",   DATA_W'(busy),        DATA_W'(1'b0));
        check("rst_data",   res_data,             {DATA_W{1'b0}});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Same AES key twice: expand once.
        push(1'b0, K1, 1, 4'd1, 1'b1, 1'b0);
        push(1'b0, K1, 2, 4'd2, 1'b0, 1'b0);
        drain("same_key");

        // AES, Keccak (cache untouched), AES with a new key.
        push(1'b0, K2, 3, 4'd3, 1'b1, 1'b0);
        push(1'b1, K2, 4, 4'd4, 1'b0, 1'b0);
        push(1'b0, K3, 5, 4'd5, 1'b1, 1'b0);
        drain("mixed");

        // Five back-to-back pushes with the core stalled.
        stall = 1'b1;
        push(1'b0, K4, 6,  4'd6,  1'b1, 1'b0);
        push(1'b0, K4, 7,  4'd7,  1'b0, 1'b0);
        push(1'b0, K4, 8,  4'd8,  1'b0, 1'b0);
        push(1'b0, K4, 9,  4'd9,  1'b0, 1'b0);
        push(1'b0, K4, 10, 4'd10, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ready", DATA_W'(req_ready), DATA_W'(1'b0));
        check("full_level", DATA_W'(level),     DATA_W'(3'd4));
        check("full_busy",  DATA_W'(busy),      DATA_W'(1'b1));
        stall = 1'b0;
        drain("full");

        // Result back-pressure: result stays put, next job is not loaded.
        res_ready = 1'b0;
        push(1'b0, K4, 11, 4'd11, 1'b0, 1'b0);
        push(1'b0, K4, 12, 4'd12, 1'b0, 1'b0);
        g = 0;
        while (res_valid !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (res_valid !== 1'b1) fail_now("hold_no_result");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", DATA_W'(res_valid), DATA_W'(1'b1));
            check("hold_data",  res_data,           ~mkdata(11));
            check("hold_level", DATA_W'(level),     DATA_W'(3'd1));
            check("hold_core",  core_din,           mkdata(11));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        drain("hold");

        // Reset in the middle of RUN with three jobs queued.
        stall = 1'b1;
        push(1'b0, K5, 13, 4'd13, 1'b1, 1'b0);
        push(1'b0, K5, 14, 4'd14, 1'b0, 1'b0);
        push(1'b0, K5, 15, 4'd15, 1'b0, 1'b0);
        push(1'b0, K5, 16, 4'd0,  1'b0, 1'b0);
        g = 0;
        while (core_aclr !== 1'b0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("mid_level", DATA_W'(level),     DATA_W'(3'd3));
        check("mid_aclr",  DATA_W'(core_aclr), DATA_W'(1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_aclr",  DATA_W'(core_aclr), DATA_W'(1'b1));
        check("arst_level", DATA_W'(level),     DATA_W'(3'd0));
        check("arst_valid", DATA_W'(res_valid), DATA_W'(1'b0));
        exp_core.delete();
        exp_res.delete();
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(1'b0, K5, 17, 4'd9, 1'b1, 1'b0);
        drain("after_reset");

`ifdef AESHA_SCHED_TMO_EN
        // Watchdog abort after TMO_CYC RUN cycles; cache is invalidated.
        stall = 1'b1;
        push(1'b0, K6, 18, 4'd7, 1'b1, 1'b1);
        g = 0;
        begin
            int runc;
            runc = 0;
            while (res_valid !== 1'b1 && g < 200) begin
                @(negedge clk);
                if (core_aclr === 1'b0) runc++;
                g++;
            end
            check("tmo_run_cycles", DATA_W'(runc), DATA_W'(TMO_CYC));
        end
        drain("tmo");
        stall = 1'b0;
        push(1'b0, K6, 19, 4'd8, 1'b1, 1'b0);
        drain("tmo_next");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
